// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit processor: opcodes, controller states and
// instruction field layout.
package cpu_pkg;

    localparam int INSTR_W = 12;
    localparam int DATA_W  = 4;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    // imm overlaps rb; which field is meaningful depends on the opcode
    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 9;
    localparam int RD_MSB  = 8;
    localparam int RD_LSB  = 7;
    localparam int RA_MSB  = 6;
    localparam int RA_LSB  = 5;
    localparam int RB_MSB  = 4;
    localparam int RB_LSB  = 3;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    function automatic logic is_alu_op(input logic [2:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    endfunction

    function automatic logic writes_rd(input logic [2:0] op);
        return is_alu_op(op) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Instruction-fetch handshake and ALU operand/opcode bus between the
// controller (master) and the memory/ALU side (slave).
interface cpu_ctrl_if #(
    parameter int IMEM_AW = 4
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_valid;
    logic [11:0]        imem_data;
    logic [3:0]         alu_a;
    logic [3:0]         alu_b;
    logic [2:0]         alu_op;
    logic [3:0]         alu_result;

    modport master (
        output imem_req, imem_addr, alu_a, alu_b, alu_op,
        input  imem_valid, imem_data, alu_result
    );

    modport slave (
        input  imem_req, imem_addr, alu_a, alu_b, alu_op,
        output imem_valid, imem_data, alu_result
    );
endinterface

// File: rtl/regfile4x4.sv
// Four 4-bit registers: one synchronous write port, three combinational read
// ports (two operands plus debug).
module regfile4x4
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [1:0]        ra_sel,
    input  logic [1:0]        rb_sel,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [4];

    // NOTE: the array sits in the reset branch because the processor must come
    // out of reset with R0-R3 at zero; that keeps it as flops, not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data  = regs[ra_sel];
    assign rb_data  = regs[rb_sel];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/cpu_ctrl.sv
// Fetch/decode/execute/write-back sequencer for the 4-bit processor; owns the
// PC, the register file, the retired counter and the halt/illegal status.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int IMEM_AW = 4,
    parameter int RET_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    cpu_ctrl_if.master         bus,
    input  logic [1:0]         dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [RET_W-1:0]   retired,
    output logic [IMEM_AW-1:0] pc
);

    state_t             state;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  res;
    logic [DATA_W-1:0]  alu_a_q;
    logic [DATA_W-1:0]  alu_b_q;
    logic [2:0]         alu_op_q;
    logic               imem_req_q;

    logic [2:0]         op;
    logic [1:0]         rd;
    logic [1:0]         ra;
    logic [1:0]         rb;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  ra_data;
    logic [DATA_W-1:0]  rb_data;
    logic               rf_we;

    assign op  = ir[OP_MSB:OP_LSB];
    assign rd  = ir[RD_MSB:RD_LSB];
    assign ra  = ir[RA_MSB:RA_LSB];
    assign rb  = ir[RB_MSB:RB_LSB];
    assign imm = ir[IMM_MSB:IMM_LSB];

    // Writes only land in WB, so a reset anywhere earlier leaves no partial update
    assign rf_we = (state == WB) && writes_rd(op);

    regfile4x4 u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .wa       (rd),
        .wd       (res),
        .ra_sel   (ra),
        .rb_sel   (rb),
        .dbg_sel  (dbg_sel),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .dbg_data (dbg_data)
    );

    // NOTE: every flop here uses <= so all branches see the pre-edge values of
    // state, ir and pc regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= '0;
            ir         <= '0;
            res        <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= OP_NOP;
            imem_req_q <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            retired    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= FETCH;
                        imem_req_q <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.imem_valid) begin
                        ir         <= bus.imem_data;
                        state      <= DECODE;
                        imem_req_q <= 1'b0;
                    end
                end
                DECODE: begin
                    if (op == OP_HALT) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        alu_a_q  <= ra_data;
                        alu_b_q  <= rb_data;
                        alu_op_q <= is_alu_op(op) ? op : OP_NOP;
                        state    <= EXEC;
                        if (op == OP_ILL) begin
                            illegal <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    res      <= (op == OP_LDI) ? imm : bus.alu_result;
                    alu_op_q <= OP_NOP;
                    state    <= WB;
                end
                WB: begin
                    pc         <= pc + 1'b1;
                    retired    <= retired + 1'b1;
                    state      <= FETCH;
                    imem_req_q <= 1'b1;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state      <= IDLE;
                    imem_req_q <= 1'b0;
                    alu_op_q   <= OP_NOP;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: directed instruction vectors, multi-cycle
// corner sequences and random programs compared against an ISA-level model.
`timescale 1ns/1ps
module tb_cpu_ctrl;

    localparam int AW = 4;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    dbg_sel;
    logic [3:0]    dbg_data;
    logic          busy;
    logic          halted;
    logic          illegal;
    logic [RW-1:0] retired;
    logic [AW-1:0] pc;

    cpu_ctrl_if #(.IMEM_AW(AW)) bus ();

    cpu_ctrl #(.IMEM_AW(AW), .RET_W(RW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.master),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .busy     (busy),
        .halted   (halted),
        .illegal  (illegal),
        .retired  (retired),
        .pc       (pc)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Environment: combinational ALU and instruction memory with wait states
    logic [11:0] mem [16];
    int fixed_stall = -1;
    int max_stall   = 0;
    int fcnt        = 0;
    int cur_stall   = 0;
    int alu_cnt     = 0;

    // NOTE: the default arm assigns on every path, so no latch is implied.
    always_comb begin
        case (bus.alu_op)
            3'b001:  bus.alu_result = bus.alu_a + bus.alu_b;
            3'b010:  bus.alu_result = bus.alu_a - bus.alu_b;
            3'b011:  bus.alu_result = bus.alu_a & bus.alu_b;
            3'b100:  bus.alu_result = bus.alu_a | bus.alu_b;
            default: bus.alu_result = 4'h0;
        endcase
    end

    assign bus.imem_data = mem[bus.imem_addr];

    always @(negedge clk) begin
        if (bus.imem_req) begin
            if (fcnt == 0) begin
                cur_stall = (fixed_stall >= 0) ? fixed_stall : int'($urandom_range(0, max_stall));
            end
            bus.imem_valid = (fcnt >= cur_stall);
            fcnt++;
        end else begin
            fcnt = 0;
            bus.imem_valid = 1'($urandom_range(0, 1));
        end
        if (bus.alu_op != 3'b000) alu_cnt++;
    end

    function automatic logic [11:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] ra, input logic [1:0] rb);
        return {op, rd, ra, rb, 3'b000};
    endfunction

    function automatic logic [11:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
        return {3'b101, rd, 3'b000, imm};
    endfunction

    localparam logic [11:0] HALT_W = 12'hC00;

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 12'h000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        dbg_sel = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        alu_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic read_reg(input int i, output logic [3:0] v);
        dbg_sel = 2'(i);
        #1;
        v = dbg_data;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_halted"}, 32'(halted), 32'(1));
    endtask

    task automatic wait_retired(input string name, input int target, input int budget);
        int n = 0;
        while (int'(retired) != target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_retired"}, 32'(retired), 32'(target));
    endtask

    task automatic check_reset_state(input string name);
        logic [3:0] v;
        check({name, "_busy"},    32'(busy),          32'(0));
        check({name, "_halted"},  32'(halted),        32'(0));
        check({name, "_illegal"}, 32'(illegal),       32'(0));
        check({name, "_retired"}, 32'(retired),       32'(0));
        check({name, "_pc"},      32'(pc),            32'(0));
        check({name, "_req"},     32'(bus.imem_req),  32'(0));
        check({name, "_addr"},    32'(bus.imem_addr), 32'(0));
        check({name, "_alu_a"},   32'(bus.alu_a),     32'(0));
        check({name, "_alu_b"},   32'(bus.alu_b),     32'(0));
        check({name, "_alu_op"},  32'(bus.alu_op),    32'(0));
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            check($sformatf("%s_r%0d", name, i), 32'(v), 32'(0));
        end
    endtask

    // Directed single-instruction vectors: r1/r2 preloaded by LDI, then op, then HALT
    typedef struct {
        string      name;
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [3:0] v1;
        logic [3:0] v2;
        logic [3:0] exp;
        logic       exp_ill;
    } vec_t;

    vec_t vecs [8];

    // ISA-level reference model for random programs
    logic [3:0] m_regs [4];
    logic [3:0] m_pc;
    int         m_ret;
    logic       m_ill;
    logic       m_halt;

    task automatic model_step();
        logic [11:0] w;
        logic [2:0]  op;
        logic [1:0]  rd, ra, rb;
        w  = mem[m_pc];
        op = w[11:9];
        rd = w[8:7];
        ra = w[6:5];
        rb = w[4:3];
        case (op)
            3'b001: m_regs[rd] = m_regs[ra] + m_regs[rb];
            3'b010: m_regs[rd] = m_regs[ra] - m_regs[rb];
            3'b011: m_regs[rd] = m_regs[ra] & m_regs[rb];
            3'b100: m_regs[rd] = m_regs[ra] | m_regs[rb];
            3'b101: m_regs[rd] = w[3:0];
            3'b110: m_halt = 1'b1;
            3'b111: m_ill = 1'b1;
            default: ;
        endcase
        if (!m_halt) begin
            m_pc  = m_pc + 4'd1;
            m_ret = m_ret + 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v;
        int n;

        vecs[0] = '{"add",     3'b001, 2'd3, 2'd1, 2'd2, 4'h5, 4'h3, 4'h8, 1'b0};
        vecs[1] = '{"sub_wrap",3'b010, 2'd0, 2'd1, 2'd2, 4'h2, 4'h5, 4'hD, 1'b0};
        vecs[2] = '{"add_self",3'b001, 2'd1, 2'd1, 2'd1, 4'h9, 4'h0, 4'h2, 1'b0};
        vecs[3] = '{"and",     3'b011, 2'd3, 2'd1, 2'd2, 4'hC, 4'hA, 4'h8, 1'b0};
        vecs[4] = '{"or",      3'b100, 2'd0, 2'd1, 2'd2, 4'hC, 4'hA, 4'hE, 1'b0};
        vecs[5] = '{"sub_neg", 3'b010, 2'd2, 2'd2, 2'd1, 4'h1, 4'h0, 4'hF, 1'b0};
        vecs[6] = '{"nop",     3'b000, 2'd1, 2'd2, 2'd2, 4'h7, 4'h4, 4'h7, 1'b0};
        vecs[7] = '{"ill",     3'b111, 2'd1, 2'd2, 2'd2, 4'h6, 4'h4, 4'h6, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        dbg_sel = 2'd0;
        clear_mem();
        do_reset();
        #1;
        check_reset_state("por");

        // Directed vectors
        for (int k = 0; k < 8; k++) begin
            clear_mem();
            mem[0] = ldi(2'd1, vecs[k].v1);
            mem[1] = ldi(2'd2, vecs[k].v2);
            mem[2] = enc(vecs[k].op, vecs[k].rd, vecs[k].ra, vecs[k].rb);
            mem[3] = HALT_W;
            do_reset();
            pulse_start();
            wait_halt(vecs[k].name, 100);
            read_reg(int'(vecs[k].rd), v);
            check({vecs[k].name, "_rd"},      32'(v),       32'(vecs[k].exp));
            check({vecs[k].name, "_retired"}, 32'(retired), 32'(3));
            check({vecs[k].name, "_pc"},      32'(pc),      32'(3));
            check({vecs[k].name, "_illegal"}, 32'(illegal), 32'(vecs[k].exp_ill));
            check({vecs[k].name, "_busy"},    32'(busy),    32'(0));
            check({vecs[k].name, "_alu_cycles"}, 32'(alu_cnt),
                  32'((vecs[k].op >= 3'b001 && vecs[k].op <= 3'b100) ? 1 : 0));
        end

        // Memory stall: valid withheld for 3 FETCH cycles
        clear_mem();
        mem[1] = HALT_W;
        fixed_stall = 3;
        do_reset();
        pulse_start();
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            check($sformatf("stall_req_%0d", k),  32'(bus.imem_req),  32'(1));
            check($sformatf("stall_addr_%0d", k), 32'(bus.imem_addr), 32'(0));
            check($sformatf("stall_ret_%0d", k),  32'(retired),       32'(0));
        end
        @(negedge clk);
        #1;
        check("stall_req_drop", 32'(bus.imem_req), 32'(0));
        wait_retired("stall", 1, 20);
        wait_halt("stall", 40);
        check("stall_pc", 32'(pc), 32'(1));
        fixed_stall = -1;

        // PC wrap over 16 NOPs, then execution continues at address 0
        clear_mem();
        max_stall = 0;
        do_reset();
        pulse_start();
        wait_retired("wrap", 16, 16 * 6 + 20);
        check("wrap_pc",   32'(pc),            32'(0));
        check("wrap_req",  32'(bus.imem_req),  32'(1));
        check("wrap_addr", 32'(bus.imem_addr), 32'(0));
        wait_retired("wrap_next", 17, 20);
        check("wrap_next_pc", 32'(pc), 32'(1));

        // Reset while the ADD is in EXEC
        clear_mem();
        mem[0] = ldi(2'd1, 4'h5);
        mem[1] = ldi(2'd2, 4'h3);
        mem[2] = enc(3'b001, 2'd3, 2'd1, 2'd2);
        mem[3] = HALT_W;
        do_reset();
        pulse_start();
        n = 0;
        #1;
        while (bus.alu_op != 3'b001 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rexec_reached", 32'(bus.alu_op), 32'(1));
        rst = 1'b1;
        #1;
        check_reset_state("rexec");
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        #1;
        check("rexec_refetch_req",  32'(bus.imem_req),  32'(1));
        check("rexec_refetch_addr", 32'(bus.imem_addr), 32'(0));
        wait_halt("rexec", 60);
        read_reg(3, v);
        check("rexec_r3", 32'(v), 32'(8));

        // Random programs against the ISA model; start toggles randomly while busy
        for (int round = 0; round < 6; round++) begin
            for (int i = 0; i < 16; i++) begin
                logic [2:0] op;
                op = 3'($urandom_range(0, 7));
                if (op == 3'b110 && $urandom_range(0, 9) != 0) op = 3'b101;
                mem[i] = {op, 9'($urandom)};
            end
            max_stall = round % 3;
            do_reset();
            for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
            m_pc = 4'h0;
            m_ret = 0;
            m_ill = 1'b0;
            m_halt = 1'b0;
            pulse_start();
            for (int s = 0; s < 30 && !m_halt; s++) begin
                model_step();
                n = 0;
                #1;
                while (n < 40 && (m_halt ? !halted : (int'(retired) != m_ret))) begin
                    @(negedge clk);
                    start = 1'($urandom_range(0, 1));
                    #1;
                    n++;
                end
                start = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    read_reg(i, v);
                    check($sformatf("rnd%0d_s%0d_r%0d", round, s, i), 32'(v), 32'(m_regs[i]));
                end
                check($sformatf("rnd%0d_s%0d_pc", round, s),      32'(pc),      32'(m_pc));
                check($sformatf("rnd%0d_s%0d_retired", round, s), 32'(retired), 32'(m_ret));
                check($sformatf("rnd%0d_s%0d_illegal", round, s), 32'(illegal), 32'(m_ill));
                check($sformatf("rnd%0d_s%0d_halted", round, s),  32'(halted),  32'(m_halt));
                @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
